// File: rtl/div_clk_meter_if.sv
// Signal bundle between a divided clock under test and its meter.
// The meter takes the slave view; whoever drives clk_in takes the master view.
interface div_clk_meter_if #(
    parameter int CNT_W = 16
);
    logic             clk_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             err;
    logic             overflow;
    logic             duty_err;

    modport master (
        output clk_in,
        input  period, high_time, period_valid, locked, err, overflow, duty_err
    );

    modport slave (
        input  clk_in,
        output period, high_time, period_valid, locked, err, overflow, duty_err
    );
endinterface

// File: rtl/div_clk_meter.sv
// Divided-clock meter: samples clk_in as data, measures period/high time, tracks lock.
// Optional 50% duty check is built only when DUTY_CHECK_EN is defined.
module div_clk_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic          clk,
    input  logic          reset,
    div_clk_meter_if.slave mon
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [MW-1:0]    MATCH_TOP = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   s_d_reg;
    logic                   s, rise, fall;
    logic [CNT_W-1:0]       cnt_reg, hcnt_reg;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [CNT_W-1:0] high_reg, high_next;
    logic [MW-1:0]    match_reg, match_next;
    logic             locked_reg, locked_next;
    logic             overflow_reg, overflow_next;
    logic             pv_reg, pv_next;
    logic             err_reg, err_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = mon.clk_in;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~s_d_reg;
    assign fall = ~s & s_d_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            s_d_reg  <= s;
        end
    end

    // Both counters restart at 1 on a rise so they read the length directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= '0;
            hcnt_reg <= '0;
        end else begin
            if (rise)
                cnt_reg <= CNT_ONE;
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + 1'b1;

            if (rise)
                hcnt_reg <= CNT_ONE;
            else if (s && hcnt_reg != CNT_MAX)
                hcnt_reg <= hcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            period_reg   <= '0;
            high_reg     <= '0;
            match_reg    <= '0;
            locked_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            pv_reg       <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            period_reg   <= period_next;
            high_reg     <= high_next;
            match_reg    <= match_next;
            locked_reg   <= locked_next;
            overflow_reg <= overflow_next;
            pv_reg       <= pv_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        period_next   = period_reg;
        high_next     = high_reg;
        match_next    = match_reg;
        locked_next   = locked_reg;
        overflow_next = overflow_reg;
        pv_next       = 1'b0;
        err_next      = 1'b0;

        if (fall && state_reg != IDLE)
            high_next = hcnt_reg;

        case (state_reg)
            IDLE: begin
                if (rise)
                    state_next = ACQ;
            end
            ACQ: begin
                if (rise) begin
                    period_next = cnt_reg;
                    pv_next     = 1'b1;
                    match_next  = '0;
                    state_next  = TRACK;
                end else if (cnt_reg == CNT_MAX) begin
                    overflow_next = 1'b1;
                    locked_next   = 1'b0;
                    match_next    = '0;
                    state_next    = IDLE;
                end
            end
            TRACK: begin
                if (rise) begin
                    period_next = cnt_reg;
                    pv_next     = 1'b1;
                    if (cnt_reg == period_reg) begin
                        if (match_reg != MATCH_TOP)
                            match_next = match_reg + 1'b1;
                    end else begin
                        match_next = '0;
                        if (locked_reg) begin
                            err_next    = 1'b1;
                            locked_next = 1'b0;
                        end
                    end
                    if (match_next == MATCH_TOP)
                        locked_next = 1'b1;
                end else if (cnt_reg == CNT_MAX) begin
                    // clk_in stalled: drop lock and wait for activity again
                    overflow_next = 1'b1;
                    locked_next   = 1'b0;
                    match_next    = '0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DUTY_CHECK_EN
    logic duty_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            duty_reg <= 1'b0;
        else
            duty_reg <= (state_reg == TRACK) && rise &&
                        ({high_reg, 1'b0} != {1'b0, cnt_reg});
    end

    assign mon.duty_err = duty_reg;
`else
    assign mon.duty_err = 1'b0;
`endif

    assign mon.period       = period_reg;
    assign mon.high_time    = high_reg;
    assign mon.period_valid = pv_reg;
    assign mon.locked       = locked_reg;
    assign mon.err          = err_reg;
    assign mon.overflow     = overflow_reg;
endmodule

// File: tb/tb_div_clk_meter.sv
// Bench for div_clk_meter: directed clk_in waveforms plus random ones, scored
// against a rise-time/period level model of the meter.
module tb_div_clk_meter;
    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int LOCK  = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    div_clk_meter_if #(.CNT_W(CNT_W)) mon ();

    div_clk_meter #(
        .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .LOCK_COUNT(LOCK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mon(mon)
    );

    always #5 clk = ~clk;

    // Reference model state: the model sees clk_in delayed by the sync latency.
    logic dl[$];
    int   cyc = 0;
    int   mstate = 0;            // 0 waiting, 1 first rise seen, 2 tracking
    int   last_rise = 0;
    int   match = 0;
    logic prev_e = 1'b0;
    int   exp_period = 0, exp_high = 0;
    logic exp_locked = 1'b0, exp_ovf = 1'b0;
    logic exp_pv = 1'b0, exp_err = 1'b0, exp_duty = 1'b0;
    int   err_seen = 0, duty_seen = 0, exp_duty_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dl.delete();
        mstate = 0; last_rise = 0; match = 0; prev_e = 1'b0;
        exp_period = 0; exp_high = 0; exp_locked = 1'b0; exp_ovf = 1'b0;
        exp_pv = 1'b0; exp_err = 1'b0; exp_duty = 1'b0;
    endtask

    task automatic model_step(input logic e);
        int p;
        exp_pv = 1'b0; exp_err = 1'b0; exp_duty = 1'b0;
        if (e && !prev_e) begin
            p = cyc - last_rise;
            if (mstate == 1) begin
                exp_period = p; exp_pv = 1'b1; match = 0; mstate = 2;
            end else if (mstate == 2) begin
                if (p == exp_period) begin
                    if (match < LOCK) match++;
                end else begin
                    match = 0;
                    if (exp_locked) begin exp_err = 1'b1; exp_locked = 1'b0; end
                end
                if (match == LOCK) exp_locked = 1'b1;
`ifdef DUTY_CHECK_EN
                exp_duty = (2 * exp_high != p);
                if (exp_duty) exp_duty_cnt++;
`endif
                exp_period = p; exp_pv = 1'b1;
            end else begin
                mstate = 1;
            end
            last_rise = cyc;
        end else begin
            if (!e && prev_e && mstate != 0) exp_high = cyc - last_rise;
            if (mstate != 0 && cyc - last_rise == MAXV) begin
                exp_ovf = 1'b1; exp_locked = 1'b0; match = 0; mstate = 0;
            end
        end
        prev_e = e;
    endtask

    task automatic tick(input logic v);
        logic e;
        mon.clk_in = v;
        @(posedge clk);
        cyc++;
        dl.push_back(v);
        e = 1'b0;
        if (dl.size() > SYNC) e = dl.pop_front();
        model_step(e);
        #1;
        chk("period_valid", 32'(mon.period_valid), 32'(exp_pv));
        chk("period", 32'(mon.period), exp_period);
        chk("high_time", 32'(mon.high_time), exp_high);
        chk("locked", 32'(mon.locked), 32'(exp_locked));
        chk("err", 32'(mon.err), 32'(exp_err));
        chk("overflow", 32'(mon.overflow), 32'(exp_ovf));
        chk("duty_err", 32'(mon.duty_err), 32'(exp_duty));
        if (mon.err === 1'b1) err_seen++;
        if (mon.duty_err === 1'b1) duty_seen++;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < hi; j++) tick(1'b1);
            for (int j = 0; j < lo; j++) tick(1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, 32'(mon.period), 0);
        chk({tag, "_high"}, 32'(mon.high_time), 0);
        chk({tag, "_pv"}, 32'(mon.period_valid), 0);
        chk({tag, "_locked"}, 32'(mon.locked), 0);
        chk({tag, "_err"}, 32'(mon.err), 0);
        chk({tag, "_ovf"}, 32'(mon.overflow), 0);
        chk({tag, "_duty"}, 32'(mon.duty_err), 0);
    endtask

    initial begin
        int err_base;
        mon.clk_in = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;
        model_reset();

        // div2 locks; period 2, high 1
        wave(1, 1, 12);
        chk("t1_period", 32'(mon.period), 2);
        chk("t1_high", 32'(mon.high_time), 1);
        chk("t1_locked", 32'(mon.locked), 1);
        chk("t1_err_none", err_seen, 0);
        $display("step div2: period=%0d high=%0d locked=%0d", mon.period, mon.high_time, mon.locked);

        // div8
        wave(4, 4, 10);
        chk("t2_period", 32'(mon.period), 8);
        chk("t2_high", 32'(mon.high_time), 4);
        chk("t2_locked", 32'(mon.locked), 1);
        $display("step div8: period=%0d high=%0d locked=%0d", mon.period, mon.high_time, mon.locked);

        // div4 locked, then switch to div8: exactly one err pulse, relock
        wave(2, 2, 10);
        chk("t3_div4_locked", 32'(mon.locked), 1);
        err_base = err_seen;
        wave(4, 4, 10);
        chk("t3_err_pulses", err_seen - err_base, 1);
        chk("t3_period", 32'(mon.period), 8);
        chk("t3_locked", 32'(mon.locked), 1);
        $display("step div4->div8: err_pulses=%0d locked=%0d", err_seen - err_base, mon.locked);

        // stall low, then div2 again
        wave(1, 1, 12);
        for (int j = 0; j < MAXV + 20; j++) tick(1'b0);
        chk("t4_overflow", 32'(mon.overflow), 1);
        chk("t4_unlocked", 32'(mon.locked), 0);
        chk("t4_period_held", 32'(mon.period), 2);
        wave(1, 1, 12);
        chk("t4_relock", 32'(mon.locked), 1);
        chk("t4_ovf_sticky", 32'(mon.overflow), 1);
        $display("step stall: overflow=%0d locked=%0d", mon.overflow, mon.locked);

        // asynchronous reset in the middle of tracking
        wave(2, 2, 10);
        reset = 1'b0;
        #1;
        chk_all_zero("t5_async");
        mon.clk_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("t5_hold");
        reset = 1'b1;
        wave(4, 4, 10);
        chk("t5_period", 32'(mon.period), 8);
        chk("t5_locked", 32'(mon.locked), 1);
        $display("step mid reset: period=%0d locked=%0d", mon.period, mon.locked);

        // random waveforms
        for (int r = 0; r < 12; r++) begin
            int hi, lo, n;
            hi = $urandom_range(1, 6);
            lo = $urandom_range(1, 6);
            n  = $urandom_range(3, 10);
            wave(hi, lo, n);
            $display("step random: hi=%0d lo=%0d n=%0d period=%0d locked=%0d",
                     hi, lo, n, mon.period, mon.locked);
        end

        // period 3, high 1: odd period
        wave(1, 2, 10);
        chk("t6_period", 32'(mon.period), 3);
        chk("t6_duty_count", duty_seen, exp_duty_cnt);
`ifndef DUTY_CHECK_EN
        chk("t6_duty_off", duty_seen, 0);
`endif
        $display("step duty: period=%0d duty_pulses=%0d", mon.period, duty_seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
